// File: rtl/input_conditioner_if.sv
// Board-input conditioner bus: raw pins in, debounced levels and edge pulses out.
// Latency: n/a (signal bundle only).
// Backpressure: none; every output is a free-running registered level or pulse.
// Ports (signals):
//   in_raw   : raw asynchronous pin levels, driven by the board/bench side
//   level    : debounced active-high level per channel
//   rise/fall: one-cycle pulses on accepted 0->1 / 1->0 level changes
//   any_rise : OR of rise, cycle-aligned with rise
interface input_conditioner_if #(
  parameter int N_CH = 8
);
  logic [N_CH-1:0] in_raw;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            any_rise;

  // Board side: drives pins, observes conditioned outputs.
  modport master (
    output in_raw,
    input  level, rise, fall, any_rise
  );

  // Conditioner side.
  modport slave (
    input  in_raw,
    output level, rise, fall, any_rise
  );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel polarity fix, N-stage synchroniser, debounce filter and rise/fall pulse generator.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clocks from a stable pin change to level/pulse.
// Backpressure: none; pulses are single-cycle and must be consumed when they occur.
// Ports:
//   clk     : rising-edge clock for all state
//   reset_n : asynchronous active-low reset, clears every flop
//   bus     : input_conditioner_if.slave (in_raw in; level, rise, fall, any_rise out)
module input_conditioner #(
  parameter int              N_CH            = 8,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 4,
  parameter logic [N_CH-1:0] ACTIVE_LOW      = '0
) (
  input logic              clk,
  input logic              reset_n,
  input_conditioner_if.slave bus
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] w_x;
  logic [N_CH-1:0] w_s;
  logic [N_CH-1:0] w_accept;
  logic [N_CH-1:0] w_rise_nxt;
  logic [N_CH-1:0] w_fall_nxt;

  logic [N_CH-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]   r_cnt  [N_CH];
  logic [N_CH-1:0] r_level;
  logic [N_CH-1:0] r_rise;
  logic [N_CH-1:0] r_fall;
  logic            r_any_rise;

  // Active-low pins are inverted before the first sync flop so that
  // everything downstream works in active-high terms.
  assign w_x = bus.in_raw ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= w_x;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Accept fires on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_accept[i] = (w_s[i] != r_level[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  assign w_rise_nxt = w_accept & w_s;
  assign w_fall_nxt = w_accept & ~w_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
      r_level    <= '0;
      r_rise     <= '0;
      r_fall     <= '0;
      r_any_rise <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_s[i] == r_level[i]) begin
          // Agreement (or a glitch returning) discards any partial count.
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_level[i] <= w_s[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_rise     <= w_rise_nxt;
      r_fall     <= w_fall_nxt;
      r_any_rise <= |w_rise_nxt;
    end
  end

  assign bus.level    = r_level;
  assign bus.rise     = r_rise;
  assign bus.fall     = r_fall;
  assign bus.any_rise = r_any_rise;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: three instances (defaults, active-low ch2, fast/no-filter).
// Latency: n/a.
// Backpressure: n/a.
module tb_input_conditioner;

  logic clk;
  logic reset_n;
  logic run;
  int   edge_n;
  int   checks;
  int   failures;

  input_conditioner_if #(.N_CH(8)) if0 ();
  input_conditioner_if #(.N_CH(8)) if1 ();
  input_conditioner_if #(.N_CH(8)) if2 ();

  input_conditioner #(
    .N_CH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(8'h00)
  ) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));

  input_conditioner #(
    .N_CH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(8'h04)
  ) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  input_conditioner #(
    .N_CH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(8'h00)
  ) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges counted from reset release (edge 1 = first edge after release).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_n = 0;
    else          edge_n = edge_n + 1;
  end

  // DUT outputs gathered into arrays for uniform checking.
  logic [7:0] d_level [3];
  logic [7:0] d_rise  [3];
  logic [7:0] d_fall  [3];
  logic       d_any   [3];
  assign d_level[0] = if0.level;  assign d_rise[0] = if0.rise;
  assign d_fall[0]  = if0.fall;   assign d_any[0]  = if0.any_rise;
  assign d_level[1] = if1.level;  assign d_rise[1] = if1.rise;
  assign d_fall[1]  = if1.fall;   assign d_any[1]  = if1.any_rise;
  assign d_level[2] = if2.level;  assign d_rise[2] = if2.rise;
  assign d_fall[2]  = if2.fall;   assign d_any[2]  = if2.any_rise;

  function automatic int sync_of(int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic int db_of(int i);
    return (i == 2) ? 1 : 4;
  endfunction

  // Model: keep the sampled-input history since reset. The synchronised value
  // after an edge is the input sampled SYNC-1 edges earlier; the level flips
  // when the last DEBOUNCE synchronised values all disagree with it.
  logic [7:0] m_xh    [3][8];
  logic [7:0] m_sh    [3][8];
  logic [7:0] m_level [3];
  logic [7:0] m_rise  [3];
  logic [7:0] m_fall  [3];
  logic [7:0] m_x;
  logic       m_flip;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 8; k++) begin
          m_xh[i][k] = 8'h00;
          m_sh[i][k] = 8'h00;
        end
        m_level[i] = 8'h00;
        m_rise[i]  = 8'h00;
        m_fall[i]  = 8'h00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_x = (i == 0) ? if0.in_raw : (i == 1) ? (if1.in_raw ^ 8'h04) : if2.in_raw;
        for (int ch = 0; ch < 8; ch++) begin
          m_flip = 1'b1;
          for (int k = 0; k < db_of(i); k++) begin
            if (m_sh[i][k][ch] == m_level[i][ch]) m_flip = 1'b0;
          end
          m_rise[i][ch] = m_flip & ~m_level[i][ch];
          m_fall[i][ch] = m_flip & m_level[i][ch];
          if (m_flip) m_level[i][ch] = ~m_level[i][ch];
        end
        for (int k = 7; k > 0; k--) begin
          m_xh[i][k] = m_xh[i][k-1];
          m_sh[i][k] = m_sh[i][k-1];
        end
        m_xh[i][0] = m_x;
        m_sh[i][0] = m_xh[i][sync_of(i)-1];
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s t=%0t edge=%0d actual=%h expected=%h", name, $time, edge_n, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cyc.dut%0d.level", i), d_level[i], m_level[i]);
        chk($sformatf("cyc.dut%0d.rise", i),  d_rise[i],  m_rise[i]);
        chk($sformatf("cyc.dut%0d.fall", i),  d_fall[i],  m_fall[i]);
        chk($sformatf("cyc.dut%0d.any_rise", i), {7'b0, d_any[i]}, {7'b0, |m_rise[i]});
      end
    end
  end

  // Advance to the negedge that follows edge n.
  task automatic to_edge(input int n);
    int guard;
    guard = 0;
    if (edge_n > n) begin
      failures = failures + 1;
      $display("FAIL seq already past edge %0d (at %0d)", n, edge_n);
    end
    while (edge_n < n) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        $display("FAIL timeout waiting for edge %0d", n);
        $fatal(1, "timeout");
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    run        = 1'b0;
    reset_n    = 1'b1;
    if0.in_raw = 8'h00;
    if1.in_raw = 8'h04;   // active-low key unpressed
    if2.in_raw = 8'h00;
    #3 reset_n = 1'b0;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.level0", if0.level, 8'h00);
    chk("rst.rise0",  if0.rise,  8'h00);
    chk("rst.level1", if1.level, 8'h00);
    reset_n = 1'b1;

    // Clean step on channel 0.
    to_edge(9);  if0.in_raw = 8'h01;
    to_edge(9);  chk("al.idle_level1", if1.level, 8'h00);
    to_edge(14); chk("step.level_e14", if0.level, 8'h00);
    to_edge(15); chk("step.level_e15", if0.level, 8'h01);
                 chk("step.rise_e15",  if0.rise,  8'h01);
                 chk("step.any_e15",   {7'b0, if0.any_rise}, 8'h01);
                 chk("model.level_e15", m_level[0], 8'h01);
    to_edge(16); chk("step.rise_e16",  if0.rise,  8'h00);
                 chk("step.level_e16", if0.level, 8'h01);

    // Active-low channel 2 on dut1.
    to_edge(20); if1.in_raw = 8'h00;
    to_edge(25); chk("al.level_e25", if1.level, 8'h00);
    to_edge(26); chk("al.rise_e26",  if1.rise,  8'h04);
                 chk("al.level_e26", if1.level, 8'h04);
    to_edge(30); if1.in_raw = 8'h04;
    to_edge(36); chk("al.fall_e36",  if1.fall,  8'h04);
                 chk("al.level_e36", if1.level, 8'h00);

    // Glitch rejection on channel 1: 3-cycle then 4-cycle high.
    to_edge(39); if0.in_raw = 8'h03;
    to_edge(42); if0.in_raw = 8'h01;
    to_edge(50); chk("glitch3.level", if0.level, 8'h01);
    to_edge(59); if0.in_raw = 8'h03;
    to_edge(63); if0.in_raw = 8'h01;
    to_edge(65); chk("glitch4.level_e65", if0.level, 8'h03);
                 chk("glitch4.rise_e65",  if0.rise,  8'h02);
    to_edge(68); chk("glitch4.level_e68", if0.level, 8'h03);
    to_edge(69); chk("glitch4.level_e69", if0.level, 8'h01);
                 chk("glitch4.fall_e69",  if0.fall,  8'h02);

    // Simultaneous multi-channel change.
    to_edge(79);  if0.in_raw = 8'h00;
    to_edge(85);  chk("sim.fall0_e85", if0.fall, 8'h01);
    to_edge(99);  if0.in_raw = 8'hA5;
    to_edge(105); chk("sim.rise_e105", if0.rise, 8'hA5);
                  chk("sim.any_e105",  {7'b0, if0.any_rise}, 8'h01);
    to_edge(106); chk("sim.rise_e106", if0.rise, 8'h00);
                  chk("sim.level_e106", if0.level, 8'hA5);
    to_edge(119); if0.in_raw = 8'h00;
    to_edge(125); chk("sim.fall_e125", if0.fall, 8'hA5);
                  chk("sim.any_e125",  {7'b0, if0.any_rise}, 8'h00);
                  chk("sim.level_e125", if0.level, 8'h00);

    // No filtering, 3-stage sync: single-cycle input pulse.
    to_edge(129); if2.in_raw = 8'h01;
    to_edge(130); if2.in_raw = 8'h00;
    to_edge(132); chk("fast.level_e132", if2.level, 8'h00);
    to_edge(133); chk("fast.level_e133", if2.level, 8'h01);
                  chk("fast.rise_e133",  if2.rise,  8'h01);
                  chk("model.level_e133", m_level[2], 8'h01);
    to_edge(134); chk("fast.level_e134", if2.level, 8'h00);
                  chk("fast.fall_e134",  if2.fall,  8'h01);
                  chk("fast.rise_e134",  if2.rise,  8'h00);

    // Reset in the middle of a debounce count; inputs held through reset.
    to_edge(139); if0.in_raw = 8'h08; if2.in_raw = 8'h80;
    to_edge(143); chk("rmid.level2_pre", if2.level, 8'h80);
                  chk("rmid.rise2_pre",  if2.rise,  8'h80);
                  chk("rmid.level0_pre", if0.level, 8'h00);
    #1 reset_n = 1'b0;
    #1;
    chk("rmid.async_level2", if2.level, 8'h00);
    chk("rmid.async_rise2",  if2.rise,  8'h00);
    chk("rmid.async_any2",   {7'b0, if2.any_rise}, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    to_edge(4); chk("rmid.rise2_e4",  if2.rise,  8'h80);
    to_edge(5); chk("rmid.level0_e5", if0.level, 8'h00);
    to_edge(6); chk("rmid.rise0_e6",  if0.rise,  8'h08);
                chk("rmid.level0_e6", if0.level, 8'h08);
                chk("rmid.any0_e6",   {7'b0, if0.any_rise}, 8'h01);
    to_edge(10);

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised front end for asynchronous board inputs (push-buttons, switches, action keys). Each channel gets:
- a configurable-depth synchroniser,
- per-bit polarity correction,
- a per-channel debounce counter,
- single-cycle rise/fall pulses.

It sits between the board pins and the control FSM. Debounced levels and one-shot edge pulses replace the raw 2-stage synchronised signals.

Parameters:
N_CH, 8, number of independent input channels (>=1)
SYNC_STAGES, 2, flip-flops in each synchroniser chain (>=2)
DEBOUNCE_CYCLES, 4, consecutive disagreeing cycles required before a level change is accepted (>=1; 1 = no filtering)
ACTIVE_LOW, {N_CH{1'b0}}, per-channel mask; bit=1 means the raw pin is active-low and is inverted before synchronisation

Ports:
clk  in  1  system clock; all state is updated on its rising edge
reset_n  in  1  asynchronous active-low reset
in_raw  in  N_CH  raw asynchronous inputs
level  out  N_CH  debounced active-high level per channel
rise  out  N_CH  1-cycle pulse when level goes 0->1
fall  out  N_CH  1-cycle pulse when level goes 1->0
any_rise  out  1  OR-reduction of rise

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous assert, active-low. Release is synchronous to clk from the system's reset generator.
- Reset values: on reset_n=0, immediately and asynchronously:
  - all sync flops, level, rise, fall, any_rise = 0;
  - all debounce counters = 0.
- Polarity: x[i] = in_raw[i] XOR ACTIVE_LOW[i], applied combinationally before sync stage 0. An unpressed active-low key (pin=1) therefore reads 0.
- Synchroniser: shift chain of SYNC_STAGES flops per channel. s[i] = last stage. No logic between stages.
- Debounce, per channel, counter cnt of width clog2(DEBOUNCE_CYCLES) (min 1):
  - s==level: cnt <= 0.
  - s!=level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s!=level and cnt == DEBOUNCE_CYCLES-1: level <= s, cnt <= 0. This is the accept event.
  - Any return of s to level before acceptance clears cnt; the glitch is discarded.
- Latency:
  - x changes before edge E1.
  - s reflects it at edge E_SYNC_STAGES.
  - level changes at edge E_(SYNC_STAGES+DEBOUNCE_CYCLES), assuming x holds.
  - Defaults: 6 clocks.
- Pulses:
  - rise[i] <= accept & s[i]; fall[i] <= accept & ~s[i]. Both are registered, so they are high in the same cycle level changes, for exactly 1 cycle.
  - rise and fall are never both high for one channel.
  - any_rise is registered as the OR of the next-state rise, so it is cycle-aligned with rise.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.
- Input toggling faster than DEBOUNCE_CYCLES: level never changes and no pulses are produced.
- Reset mid-count: cnt, level and pulses clear at once. After release the channel needs the full SYNC_STAGES+DEBOUNCE_CYCLES again.
  - An input held active through reset produces a rise pulse after release. This is intended: the FSM sees the press.
- DEBOUNCE_CYCLES=1: level is s delayed by one cycle. This is the plain-synchroniser behaviour plus edge pulses.
- No combinational path from in_raw to any output.

Test Plan:
(Defaults unless stated; edges counted from reset_n release.)
- Clean step: in_raw[0] 0->1 before edge 10 -> level[0]=1 and rise[0]=1 after edge 15. rise[0]=0 after edge 16. Other outputs stay 0.
- Glitch rejection: in_raw[1] high for 3 cycles, then low -> level[1], rise[1], fall[1] stay 0 throughout. Repeat with 4-cycle high -> level[1] pulses high, rise then fall each 1 cycle.
- Active-low: ACTIVE_LOW=8'h04, in_raw[2]=1 at reset -> level[2]=0. Drive 0 -> rise[2] after 6 clocks. Drive 1 -> fall[2] after 6 clocks.
- Simultaneous and any_rise: in_raw 8'h00->8'hA5 on one edge -> rise=8'hA5, any_rise=1 in the same single cycle, level=8'hA5 thereafter. Then 8'hA5->8'h00 -> fall=8'hA5, any_rise=0.
- Reset mid-count: raise in_raw[3]. Assert reset_n=0 after 4 clocks for 2 cycles -> outputs 0 asynchronously. After release, rise[3] exactly 6 clocks later.
- DEBOUNCE_CYCLES=1, SYNC_STAGES=3: 1-cycle input pulse -> level high 1 cycle, rise then fall on consecutive cycles; latency 4 clocks.
